bullet_pool_arbiter: RTL and testbench

Shares the enemy-bullet slot pool between several bullet emitters (boss pattern generators, stage enemies). Each cycle it picks one requesting emitter round-robin, allocates the lowest free slot and announces the spawn to the bullet datapath; the datapath returns slots when bullets leave the screen or hit. It sits between the emitters and the bullet renderer/collision logic, and is paused and cleared by the game controller through `game_en` and `game_reset`.

---
 rtl/stg_pkg.sv | 21 ++
 rtl/bullet_pool_arbiter_if.sv | 45 ++++
 rtl/rr_arbiter.sv | 34 +++
 rtl/bullet_pool_arbiter.sv | 174 +++++++++++++++++
 tb/tb_bullet_pool_arbiter.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/stg_pkg.sv
// Shared STG definitions: arbiter state encoding, default pool sizing and
// the spawn record handed to the bullet datapath.
package stg_pkg;

  localparam int DEF_N_REQ    = 4;
  localparam int DEF_N_SLOT   = 16;
  localparam int SPAWN_SLOT_W = 6;  // wide enough for the largest pool (64)
  localparam int SRC_W        = 3;  // wide enough for the largest emitter count (8)

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  typedef struct packed {
    logic                    valid;
    logic [SPAWN_SLOT_W-1:0] slot;
    logic [SRC_W-1:0]        src;
  } spawn_t;

endpackage

// File: rtl/bullet_pool_arbiter_if.sv
// Emitter/controller-facing bundle of the bullet pool arbiter.
// Optional BULLET_POOL_STATS_EN adds the drop_count statistics signal.
interface bullet_pool_arbiter_if
  import stg_pkg::*;
#(
  parameter int N_REQ  = DEF_N_REQ,
  parameter int N_SLOT = DEF_N_SLOT,
  parameter int SLOT_W = $clog2(N_SLOT)
);
  logic              game_en;
  logic              game_reset;
  logic [N_REQ-1:0]  req;
  logic              release_valid;
  logic [SLOT_W-1:0] release_slot;
  logic [N_REQ-1:0]  gnt;
  logic              spawn_valid;
  logic [SLOT_W-1:0] spawn_slot;
  logic [2:0]        spawn_src;
  logic [N_SLOT-1:0] slot_busy;
  logic [SLOT_W:0]   free_count;
  logic              pool_full;
  logic              ready;
`ifdef BULLET_POOL_STATS_EN
  logic [15:0]       drop_count;
`endif

  modport master (
    output game_en, game_reset, req, release_valid, release_slot,
    input  gnt, spawn_valid, spawn_slot, spawn_src, slot_busy,
    input  free_count, pool_full, ready
`ifdef BULLET_POOL_STATS_EN
    , input drop_count
`endif
  );

  modport slave (
    input  game_en, game_reset, req, release_valid, release_slot,
    output gnt, spawn_valid, spawn_slot, spawn_src, slot_busy,
    output free_count, pool_full, ready
`ifdef BULLET_POOL_STATS_EN
    , output drop_count
`endif
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set req bit after ptr, with wrap.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     win_oh,
  output logic [IDX_W-1:0] win_idx
);

  logic             found;
  int unsigned      cand;
  logic [IDX_W-1:0] cand_idx;

  // Scan ptr+1 .. ptr+N (mod N); ptr itself is visited last.
  always_comb begin
    win_oh   = '0;
    win_idx  = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand     = (32'(ptr) + k) % N;
      cand_idx = IDX_W'(cand);
      if (!found && req[cand_idx]) begin
        found           = 1'b1;
        win_oh[cand_idx] = 1'b1;
        win_idx         = cand_idx;
      end
    end
  end

endmodule

// File: rtl/bullet_pool_arbiter.sv
// Bullet slot pool arbiter: round-robin emitter grant, lowest-free slot
// allocation, slot release and a one-slot-per-cycle clear sweep.
// Optional BULLET_POOL_STATS_EN adds a saturating drop_count statistic.
module bullet_pool_arbiter
  import stg_pkg::*;
#(
  parameter int N_REQ  = DEF_N_REQ,
  parameter int N_SLOT = DEF_N_SLOT,
  parameter int SLOT_W = $clog2(N_SLOT)
) (
  input logic                  clk,
  input logic                  hard_reset,
  bullet_pool_arbiter_if.slave bus
);

  localparam int                IDX_W     = $clog2(N_REQ);
  localparam logic [IDX_W-1:0]  PTR_RST   = IDX_W'(N_REQ - 1);
  localparam logic [SLOT_W:0]   FULL_CNT  = (SLOT_W + 1)'(N_SLOT);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(N_SLOT - 1);

  state_e            state_q, state_d;
  logic [N_SLOT-1:0] busy_q, busy_d;
  logic [SLOT_W:0]   free_q, free_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [SLOT_W-1:0] sweep_q, sweep_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  spawn_t            spawn_q, spawn_d;
`ifdef BULLET_POOL_STATS_EN
  logic [15:0]       drop_q, drop_d;
`endif

  logic [N_REQ-1:0]  win_oh;
  logic [IDX_W-1:0]  win_idx;
  logic [SLOT_W-1:0] free_slot;
  logic              free_found;
  logic              pool_full;
  logic              alloc;
  logic              rel_ok;

  rr_arbiter #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req     (bus.req),
    .ptr     (ptr_q),
    .win_oh  (win_oh),
    .win_idx (win_idx)
  );

  assign pool_full = (free_q == '0);

  // Lowest-index free slot of the registered occupancy map.
  always_comb begin
    free_slot  = '0;
    free_found = 1'b0;
    for (int unsigned s = 0; s < N_SLOT; s++) begin
      if (!free_found && !busy_q[s]) begin
        free_found = 1'b1;
        free_slot  = SLOT_W'(s);
      end
    end
  end

  // Next-state: grant/allocate/release in RUN, slot sweep in CLEAR.
  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    free_d  = free_q;
    ptr_d   = ptr_q;
    sweep_d = sweep_q;
    gnt_d   = '0;
    spawn_d = '0;
    alloc   = 1'b0;
    rel_ok  = 1'b0;
`ifdef BULLET_POOL_STATS_EN
    drop_d  = drop_q;
`endif
    case (state_q)
      ST_RUN: begin
        if (bus.game_reset) begin
          state_d = ST_CLEAR;
          sweep_d = '0;
`ifdef BULLET_POOL_STATS_EN
          drop_d  = '0;
`endif
        end else begin
          rel_ok = bus.release_valid && busy_q[bus.release_slot];
          alloc  = bus.game_en && (|bus.req) && !pool_full;
          // Allocation uses the pre-release map, so it never picks the
          // slot being returned in the same cycle.
          if (alloc) begin
            busy_d[free_slot] = 1'b1;
            gnt_d             = win_oh;
            ptr_d             = win_idx;
            spawn_d.valid     = 1'b1;
            spawn_d.slot      = SPAWN_SLOT_W'(free_slot);
            spawn_d.src       = SRC_W'(win_idx);
          end
          if (rel_ok) begin
            busy_d[bus.release_slot] = 1'b0;
          end
          free_d = free_q - (SLOT_W + 1)'(alloc) + (SLOT_W + 1)'(rel_ok);
`ifdef BULLET_POOL_STATS_EN
          if (bus.game_en && (|bus.req) && pool_full && (drop_q != '1)) begin
            drop_d = drop_q + 16'd1;
          end
`endif
        end
      end
      ST_CLEAR: begin
        if (bus.game_reset) begin
          sweep_d = '0;
`ifdef BULLET_POOL_STATS_EN
          drop_d  = '0;
`endif
        end else begin
          busy_d[sweep_q] = 1'b0;
          if (busy_q[sweep_q]) begin
            free_d = free_q + 1'b1;
          end
          if (sweep_q == LAST_SLOT) begin
            state_d = ST_RUN;
            free_d  = FULL_CNT;
            ptr_d   = PTR_RST;
            sweep_d = '0;
          end else begin
            sweep_d = sweep_q + 1'b1;
          end
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // State registers with synchronous hard reset.
  always_ff @(posedge clk) begin
    if (hard_reset) begin
      state_q <= ST_RUN;
      busy_q  <= '0;
      free_q  <= FULL_CNT;
      ptr_q   <= PTR_RST;
      sweep_q <= '0;
      gnt_q   <= '0;
      spawn_q <= '0;
`ifdef BULLET_POOL_STATS_EN
      drop_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      free_q  <= free_d;
      ptr_q   <= ptr_d;
      sweep_q <= sweep_d;
      gnt_q   <= gnt_d;
      spawn_q <= spawn_d;
`ifdef BULLET_POOL_STATS_EN
      drop_q  <= drop_d;
`endif
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.spawn_valid = spawn_q.valid;
  assign bus.spawn_slot  = spawn_q.slot[SLOT_W-1:0];
  assign bus.spawn_src   = spawn_q.src;
  assign bus.slot_busy   = busy_q;
  assign bus.free_count  = free_q;
  assign bus.pool_full   = pool_full;
  assign bus.ready       = (state_q == ST_RUN);
`ifdef BULLET_POOL_STATS_EN
  assign bus.drop_count  = drop_q;
`endif

endmodule

// File: tb/tb_bullet_pool_arbiter.sv
// Directed bench for bullet_pool_arbiter (N_REQ=4, N_SLOT=16).
module tb_bullet_pool_arbiter;

  logic clk = 1'b0;
  logic hard_reset;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  bullet_pool_arbiter_if #(.N_REQ(4), .N_SLOT(16)) bus ();

  bullet_pool_arbiter #(.N_REQ(4), .N_SLOT(16)) dut (
    .clk        (clk),
    .hard_reset (hard_reset),
    .bus        (bus)
  );

  typedef struct {
    logic        en;
    logic [3:0]  req;
    logic        rv;
    logic [3:0]  rs;
    logic [3:0]  gnt;
    logic        sv;
    logic [3:0]  slot;
    logic [2:0]  src;
    logic [4:0]  free;
    logic [15:0] busy;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic [3:0] req, input logic rv, input logic [3:0] rs);
    bus.game_en       = en;
    bus.req           = req;
    bus.release_valid = rv;
    bus.release_slot  = rs;
  endtask

  initial begin
    int n;
    //            en   req   rv   rs    gnt   sv  slot src free busy
    vecs[0]  = '{1'b1, 4'h5, 1'b0, 4'd0, 4'h1, 1'b1, 4'd0, 3'd0, 5'd15, 16'h0001};
    vecs[1]  = '{1'b1, 4'h5, 1'b0, 4'd0, 4'h4, 1'b1, 4'd1, 3'd2, 5'd14, 16'h0003};
    vecs[2]  = '{1'b1, 4'h5, 1'b0, 4'd0, 4'h1, 1'b1, 4'd2, 3'd0, 5'd13, 16'h0007};
    vecs[3]  = '{1'b1, 4'h5, 1'b0, 4'd0, 4'h4, 1'b1, 4'd3, 3'd2, 5'd12, 16'h000F};
    vecs[4]  = '{1'b1, 4'h0, 1'b1, 4'd3, 4'h0, 1'b0, 4'd0, 3'd0, 5'd13, 16'h0007};
    vecs[5]  = '{1'b1, 4'h1, 1'b1, 4'd0, 4'h1, 1'b1, 4'd3, 3'd0, 5'd13, 16'h000E};
    vecs[6]  = '{1'b1, 4'h1, 1'b0, 4'd0, 4'h1, 1'b1, 4'd0, 3'd0, 5'd12, 16'h000F};
    vecs[7]  = '{1'b1, 4'h0, 1'b1, 4'd9, 4'h0, 1'b0, 4'd0, 3'd0, 5'd12, 16'h000F};
    vecs[8]  = '{1'b0, 4'hF, 1'b1, 4'd1, 4'h0, 1'b0, 4'd0, 3'd0, 5'd13, 16'h000D};
    vecs[9]  = '{1'b1, 4'hF, 1'b0, 4'd0, 4'h2, 1'b1, 4'd1, 3'd1, 5'd12, 16'h000F};
    vecs[10] = '{1'b1, 4'hA, 1'b0, 4'd0, 4'h8, 1'b1, 4'd4, 3'd3, 5'd11, 16'h001F};
    vecs[11] = '{1'b1, 4'hA, 1'b0, 4'd0, 4'h2, 1'b1, 4'd5, 3'd1, 5'd10, 16'h003F};

    hard_reset     = 1'b1;
    bus.game_reset = 1'b0;
    drive(1'b0, 4'h0, 1'b0, 4'd0);
    step();
    step();
    hard_reset = 1'b0;
    check("rst_busy", 32'(bus.slot_busy), 32'h0);
    check("rst_free", 32'(bus.free_count), 32'd16);
    check("rst_full", 32'(bus.pool_full), 32'd0);
    check("rst_ready", 32'(bus.ready), 32'd1);
    check("rst_gnt", 32'(bus.gnt), 32'd0);
    check("rst_valid", 32'(bus.spawn_valid), 32'd0);
    check("rst_slot", 32'(bus.spawn_slot), 32'd0);
    check("rst_src", 32'(bus.spawn_src), 32'd0);
`ifdef BULLET_POOL_STATS_EN
    check("rst_drop", 32'(bus.drop_count), 32'd0);
`endif

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].en, vecs[i].req, vecs[i].rv, vecs[i].rs);
      step();
      check($sformatf("v%0d_gnt", i), 32'(bus.gnt), 32'(vecs[i].gnt));
      check($sformatf("v%0d_valid", i), 32'(bus.spawn_valid), 32'(vecs[i].sv));
      if (vecs[i].sv) begin
        check($sformatf("v%0d_slot", i), 32'(bus.spawn_slot), 32'(vecs[i].slot));
        check($sformatf("v%0d_src", i), 32'(bus.spawn_src), 32'(vecs[i].src));
      end
      check($sformatf("v%0d_free", i), 32'(bus.free_count), 32'(vecs[i].free));
      check($sformatf("v%0d_busy", i), 32'(bus.slot_busy), 32'(vecs[i].busy));
    end

    // Fill the remaining 10 slots, then starve emitter 0 for 5 cycles.
    drive(1'b1, 4'h1, 1'b0, 4'd0);
    for (int i = 0; i < 10; i++) step();
    check("fill_free", 32'(bus.free_count), 32'd0);
    check("fill_full", 32'(bus.pool_full), 32'd1);
    check("fill_busy", 32'(bus.slot_busy), 32'hFFFF);
    for (int i = 0; i < 5; i++) begin
      step();
      check("full_gnt", 32'(bus.gnt), 32'd0);
      check("full_valid", 32'(bus.spawn_valid), 32'd0);
    end
`ifdef BULLET_POOL_STATS_EN
    check("drop_cnt", 32'(bus.drop_count), 32'd5);
`endif
    drive(1'b1, 4'h0, 1'b1, 4'd7);
    step();
    check("rel7_free", 32'(bus.free_count), 32'd1);
    check("rel7_full", 32'(bus.pool_full), 32'd0);
    drive(1'b1, 4'h1, 1'b0, 4'd0);
    step();
    check("re_gnt", 32'(bus.gnt), 32'h1);
    check("re_slot", 32'(bus.spawn_slot), 32'd7);
    check("re_free", 32'(bus.free_count), 32'd0);

    // Free slots 0..5 so 10 remain busy, then sweep with all emitters asking.
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 4'h0, 1'b1, 4'(i));
      step();
    end
    check("pre_clr_free", 32'(bus.free_count), 32'd6);
    drive(1'b1, 4'hF, 1'b0, 4'd0);
    bus.game_reset = 1'b1;
    step();
    bus.game_reset = 1'b0;
    check("clr0_ready", 32'(bus.ready), 32'd0);
    check("clr0_gnt", 32'(bus.gnt), 32'd0);
`ifdef BULLET_POOL_STATS_EN
    check("clr_drop", 32'(bus.drop_count), 32'd0);
`endif
    for (int i = 1; i < 16; i++) begin
      step();
      check($sformatf("clr%0d_ready", i), 32'(bus.ready), 32'd0);
      check($sformatf("clr%0d_gnt", i), 32'(bus.gnt), 32'd0);
    end
    step();
    check("clr_done_ready", 32'(bus.ready), 32'd1);
    check("clr_done_free", 32'(bus.free_count), 32'd16);
    check("clr_done_busy", 32'(bus.slot_busy), 32'h0);
    check("clr_done_gnt", 32'(bus.gnt), 32'd0);
    step();
    check("post_clr_gnt", 32'(bus.gnt), 32'h1);
    check("post_clr_slot", 32'(bus.spawn_slot), 32'd0);
    check("post_clr_src", 32'(bus.spawn_src), 32'd0);

    // Second game_reset at sweep cycle 8 restarts the sweep.
    drive(1'b1, 4'h0, 1'b0, 4'd0);
    bus.game_reset = 1'b1;
    step();
    bus.game_reset = 1'b0;
    for (int i = 0; i < 7; i++) step();
    check("rs_mid_ready", 32'(bus.ready), 32'd0);
    bus.game_reset = 1'b1;
    step();
    bus.game_reset = 1'b0;
    n = 0;
    while (!bus.ready && n < 40) begin
      step();
      n++;
    end
    check("restart_len", 32'(n), 32'd16);
    check("restart_free", 32'(bus.free_count), 32'd16);

    // Paused: no grants but releases still land.
    drive(1'b1, 4'h1, 1'b0, 4'd0);
    step();
    check("pre_pause_gnt", 32'(bus.gnt), 32'h1);
    check("pre_pause_free", 32'(bus.free_count), 32'd15);
    drive(1'b0, 4'hF, 1'b1, 4'd0);
    step();
    check("pause_gnt", 32'(bus.gnt), 32'd0);
    check("pause_free", 32'(bus.free_count), 32'd16);
    check("pause_busy", 32'(bus.slot_busy), 32'h0);
    drive(1'b0, 4'hF, 1'b0, 4'd0);
    step();
    check("pause2_gnt", 32'(bus.gnt), 32'd0);

    // Hard reset aborts a sweep in progress.
    drive(1'b1, 4'h1, 1'b0, 4'd0);
    step();
    step();
    drive(1'b1, 4'h0, 1'b0, 4'd0);
    bus.game_reset = 1'b1;
    step();
    bus.game_reset = 1'b0;
    step();
    step();
    hard_reset = 1'b1;
    step();
    hard_reset = 1'b0;
    check("hr_ready", 32'(bus.ready), 32'd1);
    check("hr_free", 32'(bus.free_count), 32'd16);
    check("hr_busy", 32'(bus.slot_busy), 32'h0);
    drive(1'b1, 4'hF, 1'b0, 4'd0);
    step();
    check("hr_gnt", 32'(bus.gnt), 32'h1);
    check("hr_slot", 32'(bus.spawn_slot), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
